// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide co-unit: funct codes, divider FSM
// state encodings and iteration count.
package mult_div_unit_pkg;

  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef logic [5:0] funct_t;

  // SPECIAL funct codes
  localparam funct_t FUNCT_MULT    = 6'b011000;
  localparam funct_t FUNCT_MULTU   = 6'b011001;
  localparam funct_t FUNCT_DIV     = 6'b011010;
  localparam funct_t FUNCT_DIVU    = 6'b011011;
  // SPECIAL2 funct codes
  localparam funct_t FUNCT2_MADD   = 6'b000000;
  localparam funct_t FUNCT2_MADDU  = 6'b000001;
  localparam funct_t FUNCT2_MUL    = 6'b000010;
  localparam funct_t FUNCT2_MSUB   = 6'b000100;
  localparam funct_t FUNCT2_MSUBU  = 6'b000101;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ON   = 2'b01,
    DIV_END  = 2'b10
  } div_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage <-> multiply/divide co-unit connection bundle.
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  funct_t      funct;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        flush;
  logic        stall_hold;
  logic        mult_div_done;
  logic [63:0] mult_div_result;

  modport master (
    output funct, operand_1, operand_2, hi_i, lo_i, flush, stall_hold,
    input  mult_div_done, mult_div_result
  );

  modport slave (
    input  funct, operand_1, operand_2, hi_i, lo_i, flush, stall_hold,
    output mult_div_done, mult_div_result
  );

endinterface

// File: rtl/mult_div_unit_div_core.sv
// Iterative radix-2 restoring unsigned divider with start/abort/hold.
// Optional MULT_DIV_DIV_ZERO_FAST_EN: zero divisor skips straight to DIV_END.
module div_core
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        hold,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        idle,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [31:0]      quot_r, rem_r, div_r;
  logic [32:0]      partial_s, diff_s;

  // Next-state selection and trial subtraction
  always_comb begin
    state_nxt_s = state_r;
    partial_s   = {rem_r, quot_r[31]};
    diff_s      = partial_s - {1'b0, div_r};
    if (abort) begin
      state_nxt_s = DIV_IDLE;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start) begin
`ifdef MULT_DIV_DIV_ZERO_FAST_EN
            if (divisor == 32'd0) begin
              state_nxt_s = DIV_END;
            end else begin
              state_nxt_s = DIV_ON;
            end
`else
            state_nxt_s = DIV_ON;
`endif
          end else begin
            state_nxt_s = DIV_IDLE;
          end
        end
        DIV_ON: begin
          if (count_r == CNT_LAST) begin
            state_nxt_s = DIV_END;
          end else begin
            state_nxt_s = DIV_ON;
          end
        end
        DIV_END: begin
          if (hold) begin
            state_nxt_s = DIV_END;
          end else begin
            state_nxt_s = DIV_IDLE;
          end
        end
        default: state_nxt_s = DIV_IDLE;
      endcase
    end
  end

  // State register and quotient/remainder datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= DIV_IDLE;
      count_r <= {CNT_W{1'b0}};
      quot_r  <= 32'd0;
      rem_r   <= 32'd0;
      div_r   <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        DIV_IDLE: begin
          if (start && !abort) begin
            count_r <= {CNT_W{1'b0}};
            div_r   <= divisor;
`ifdef MULT_DIV_DIV_ZERO_FAST_EN
            if (divisor == 32'd0) begin
              quot_r <= 32'hFFFF_FFFF;
              rem_r  <= dividend;
            end else begin
              quot_r <= dividend;
              rem_r  <= 32'd0;
            end
`else
            quot_r <= dividend;
            rem_r  <= 32'd0;
`endif
          end
        end
        DIV_ON: begin
          if (!abort) begin
            // diff_s[32] set means the trial subtraction went negative: restore
            rem_r   <= diff_s[32] ? partial_s[31:0] : diff_s[31:0];
            quot_r  <= {quot_r[30:0], ~diff_s[32]};
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign idle      = (state_r == DIV_IDLE);
  assign done      = (state_r == DIV_END);
  assign quotient  = quot_r;
  assign remainder = rem_r;

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide co-unit: combinational multiply/accumulate plus a signed
// wrapper around div_core. Optional macro: MULT_DIV_DIV_ZERO_FAST_EN.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mult_div_unit_if.slave    bus
);

  logic        mult_hit_s, mult_signed_s, acc_add_s, acc_sub_s;
  logic        div_hit_s, div_signed_s, start_s, zero_fast_s;
  logic [63:0] prod_a_s, prod_b_s, prod_s, mult_res_s;
  logic [31:0] dividend_s, divisor_s, quot_s, rem_s;
  logic        core_idle_s, core_done_s;
  logic        neg_q_r, neg_r_r;
  logic        done_s;
  logic [63:0] result_s;

  // Funct decode
  always_comb begin
    mult_hit_s    = 1'b0;
    mult_signed_s = 1'b0;
    acc_add_s     = 1'b0;
    acc_sub_s     = 1'b0;
    div_hit_s     = 1'b0;
    div_signed_s  = 1'b0;
    case (bus.funct)
      FUNCT_MULT, FUNCT2_MUL: begin mult_hit_s = 1'b1; mult_signed_s = 1'b1; end
      FUNCT_MULTU:   mult_hit_s = 1'b1;
      FUNCT2_MADD:   begin mult_hit_s = 1'b1; mult_signed_s = 1'b1; acc_add_s = 1'b1; end
      FUNCT2_MADDU:  begin mult_hit_s = 1'b1; acc_add_s = 1'b1; end
      FUNCT2_MSUB:   begin mult_hit_s = 1'b1; mult_signed_s = 1'b1; acc_sub_s = 1'b1; end
      FUNCT2_MSUBU:  begin mult_hit_s = 1'b1; acc_sub_s = 1'b1; end
      FUNCT_DIV:     begin div_hit_s = 1'b1; div_signed_s = 1'b1; end
      FUNCT_DIVU:    div_hit_s = 1'b1;
      default: begin
      end
    endcase
  end

  // Extending to 64 bits and keeping the low 64 product bits gives both
  // signed and unsigned products modulo 2^64.
  assign prod_a_s = {(mult_signed_s ? {32{bus.operand_1[31]}} : 32'd0), bus.operand_1};
  assign prod_b_s = {(mult_signed_s ? {32{bus.operand_2[31]}} : 32'd0), bus.operand_2};
  assign prod_s   = prod_a_s * prod_b_s;

  // Accumulate into {hi,lo} where requested
  always_comb begin
    if (acc_add_s) begin
      mult_res_s = {bus.hi_i, bus.lo_i} + prod_s;
    end else if (acc_sub_s) begin
      mult_res_s = {bus.hi_i, bus.lo_i} - prod_s;
    end else begin
      mult_res_s = prod_s;
    end
  end

`ifdef MULT_DIV_DIV_ZERO_FAST_EN
  assign zero_fast_s = (bus.operand_2 == 32'd0);
`else
  assign zero_fast_s = 1'b0;
`endif

  assign start_s    = core_idle_s && div_hit_s && !bus.flush;
  assign dividend_s = (div_signed_s && !zero_fast_s) ? abs32(bus.operand_1) : bus.operand_1;
  assign divisor_s  = div_signed_s ? abs32(bus.operand_2) : bus.operand_2;

  // Sign fix-up flags captured with the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (start_s) begin
      neg_q_r <= div_signed_s && !zero_fast_s && (bus.operand_1[31] ^ bus.operand_2[31]);
      neg_r_r <= div_signed_s && !zero_fast_s && bus.operand_1[31];
    end
  end

  div_core u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_s),
    .abort     (bus.flush),
    .hold      (bus.stall_hold),
    .dividend  (dividend_s),
    .divisor   (divisor_s),
    .idle      (core_idle_s),
    .done      (core_done_s),
    .quotient  (quot_s),
    .remainder (rem_s)
  );

  // Output mux; reset and flush force a silent bus
  always_comb begin
    done_s   = 1'b0;
    result_s = 64'd0;
    if (!rst_n || bus.flush) begin
      done_s   = 1'b0;
      result_s = 64'd0;
    end else if (core_done_s) begin
      done_s   = 1'b1;
      result_s = {(neg_r_r ? neg32(rem_s) : rem_s), (neg_q_r ? neg32(quot_s) : quot_s)};
    end else if (core_idle_s && mult_hit_s) begin
      done_s   = 1'b1;
      result_s = mult_res_s;
    end else begin
      done_s   = 1'b0;
      result_s = 64'd0;
    end
  end

  assign bus.mult_div_done   = done_s;
  assign bus.mult_div_result = result_s;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (multiply, divide, stall, flush, reset).
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam funct_t FUNCT_ADD = 6'b100000;

  logic clk;
  logic rst_n;
  int   checks_r;
  int   failures_r;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mul_vec(input string tag, input funct_t f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input logic exp_done, input logic [63:0] exp_res);
    @(negedge clk);
    bus.funct = f; bus.operand_1 = a; bus.operand_2 = b; bus.hi_i = hi; bus.lo_i = lo;
    #1;
    check_val({tag, "_done"}, {63'd0, bus.mult_div_done}, {63'd0, exp_done});
    check_val({tag, "_result"}, bus.mult_div_result, exp_res);
  endtask

  // Present a division in cycle 0, scramble operands afterwards, count cycles to done
  task automatic run_div(input string tag, input funct_t f, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.flush = 1'b0; bus.funct = f; bus.operand_1 = a; bus.operand_2 = b;
    #1;
    check_val({tag, "_cycle0_done"}, {63'd0, bus.mult_div_done}, 64'd0);
    lat = 0;
    while (bus.mult_div_done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      bus.operand_1 = ~a;
      bus.operand_2 = 32'h0000_0003;
      #1;
      lat++;
    end
    check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_result"}, bus.mult_div_result, exp_res);
  endtask

  initial begin
    checks_r   = 0;
    failures_r = 0;
    rst_n = 1'b0;
    bus.funct = FUNCT_MULT; bus.operand_1 = 32'hFFFF_FFFF; bus.operand_2 = 32'h0000_0002;
    bus.hi_i = 32'd0; bus.lo_i = 32'd0; bus.flush = 1'b0; bus.stall_hold = 1'b0;
    #2;
    check_val("reset_done", {63'd0, bus.mult_div_done}, 64'd0);
    check_val("reset_result", bus.mult_div_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mul_vec("mult",   FUNCT_MULT,   32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    mul_vec("multu",  FUNCT_MULTU,  32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 1'b1, 64'h0000_0001_FFFF_FFFE);
    mul_vec("madd",   FUNCT2_MADD,  32'h3, 32'h4, 32'h0, 32'h5, 1'b1, 64'h0000_0000_0000_0011);
    mul_vec("msubu",  FUNCT2_MSUBU, 32'h1, 32'h1, 32'h0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    mul_vec("maddu",  FUNCT2_MADDU, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'hFFFF_FFFF, 1'b1, 64'h0000_0002_FFFF_FFFD);
    mul_vec("msub",   FUNCT2_MSUB,  32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 1'b1, 64'h0000_0000_0000_0002);
    mul_vec("mul",    FUNCT2_MUL,   32'hFFFF_FFFD, 32'h3, 32'h0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF7);
    mul_vec("nonmd",  FUNCT_ADD,    32'h1234_5678, 32'h9, 32'h0, 32'h0, 1'b0, 64'd0);
    bus.flush = 1'b1;
    mul_vec("mult_flush", FUNCT_MULT, 32'h7, 32'h3, 32'h0, 32'h0, 1'b0, 64'd0);
    bus.flush = 1'b0;

    run_div("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
    run_div("div_wrap", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);

    @(negedge clk);
    bus.funct = FUNCT_ADD;
    bus.stall_hold = 1'b1;
    run_div("div_m7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check_val("hold_done", {63'd0, bus.mult_div_done}, 64'd1);
      check_val("hold_result", bus.mult_div_result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    @(negedge clk);
    bus.stall_hold = 1'b0;
    #1;
    check_val("hold_last_done", {63'd0, bus.mult_div_done}, 64'd1);
    @(negedge clk);
    bus.funct = FUNCT_ADD;
    #1;
    check_val("after_hold_done", {63'd0, bus.mult_div_done}, 64'd0);

    // Flush part-way through a division, then a fresh one must take full latency
    @(negedge clk);
    bus.funct = FUNCT_DIV; bus.operand_1 = 32'd1000; bus.operand_2 = 32'd3;
    for (int i = 0; i < 10; i++) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check_val("flush_done", {63'd0, bus.mult_div_done}, 64'd0);
    check_val("flush_result", bus.mult_div_result, 64'd0);
    run_div("divu_9_3", FUNCT_DIVU, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

    // Flush in the same cycle as a start must suppress the start
    @(negedge clk);
    bus.funct = FUNCT_DIVU; bus.operand_1 = 32'd9; bus.operand_2 = 32'd3; bus.flush = 1'b1;
    #1;
    check_val("flush_start_done", {63'd0, bus.mult_div_done}, 64'd0);
    run_div("divu_50_5", FUNCT_DIVU, 32'd50, 32'd5, {32'h0, 32'hA}, 33);

`ifdef MULT_DIV_DIV_ZERO_FAST_EN
    run_div("divu_5_0", FUNCT_DIVU, 32'd5, 32'd0, {32'h5, 32'hFFFF_FFFF}, 1);
`else
    run_div("divu_5_0", FUNCT_DIVU, 32'd5, 32'd0, {32'h5, 32'hFFFF_FFFF}, 33);
`endif

    // Asynchronous reset while a finished division is being held
    @(negedge clk);
    bus.funct = FUNCT_ADD;
    bus.stall_hold = 1'b1;
    run_div("divu_20_6", FUNCT_DIVU, 32'd20, 32'd6, {32'h2, 32'h3}, 33);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_done", {63'd0, bus.mult_div_done}, 64'd0);
    check_val("async_rst_result", bus.mult_div_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.stall_hold = 1'b0;
    bus.funct = FUNCT_ADD;
    run_div("post_rst_divu", FUNCT_DIVU, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Arithmetic co-unit feeding the EX stage's `mult_div_done` and `mult_div_result` inputs.
- Computes 64-bit `{hi,lo}` results for MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU and the low word for MUL.
- Multiplication is single-cycle combinational.
- Division is a 32-iteration radix-2 restoring FSM that holds EX stalled until done.

Parameters:
- DIV_CYCLES, 32, number of quotient iterations; must equal data width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- funct  in  6 (`FUNCT_BUS`)  ID/EX funct code, same encoding as EX (`FUNCT_*`/`FUNCT2_*`).
- operand_1  in  32  rs value; dividend / multiplicand.
- operand_2  in  32  rt value; divisor / multiplier.
- hi_i  in  32  current HI, used as accumulator for MADD/MSUB.
- lo_i  in  32  current LO, used as accumulator.
- flush  in  1  pipeline flush (exception/eret); aborts division.
- stall_hold  in  1  downstream stall; EX instruction does not advance this cycle.
- mult_div_done  out  1  result valid for the instruction currently in EX.
- mult_div_result  out  64  `{hi,lo}`; for MUL only [31:0] is consumed.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, count=0, quotient/remainder/divisor regs=0, mult_div_done=0, mult_div_result=0.
- Multiply path (combinational, done=1 same cycle, no state change):
  - MULT/MUL: signed 32x32.
  - MULTU: unsigned 32x32.
  - MADD: `{hi_i,lo_i}` + signed product; MADDU: same with unsigned product.
  - MSUB: `{hi_i,lo_i}` - signed product; MSUBU: same with unsigned product.
  - All arithmetic is modulo 2^64.
- Division FSM states: IDLE, DIV_ON, DIV_END.
- IDLE:
  - funct ∈ {DIV, DIVU} and !flush → latch operand magnitudes and sign flags, count=0, go DIV_ON.
  - done=0 for DIV/DIVU in IDLE.
- DIV_ON:
  - Each cycle: shift partial remainder left, trial-subtract divisor, set quotient bit, count++.
  - After count reaches DIV_CYCLES-1 (32 cycles in DIV_ON) → DIV_END.
  - done=0 throughout.
- DIV_END:
  - done=1; result = `{remainder, quotient}` with signs applied.
  - Next state IDLE, unless stall_hold=1, in which case it stays in DIV_END with the result held.
- Timing: DIV seen in EX in cycle 0 → done=1 in cycle 33 (33 stall cycles). A back-to-back DIV starts from IDLE in cycle 34.
- Signed rules (DIV):
  - |op1| / |op2| computed unsigned.
  - Quotient negated if op1[31]^op2[31].
  - Remainder negated if op1[31].
  - 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0 (wraps).
- flush=1 in any state → IDLE next cycle, done=0, and no result leaks. Flush outranks a start in the same cycle.
- Operand changes while in DIV_ON are ignored, because latched copies are used.
- Divide by zero without the feature: runs the full 32 cycles. Result: quotient=0xFFFFFFFF, remainder=dividend (unsigned path); signs are applied afterwards for DIV.
- Non-mult/div funct: done=0, result=0.

Optional Feature:
- Macro: MULT_DIV_DIV_ZERO_FAST_EN.
- Defined: divisor==0 in IDLE → go directly to DIV_END (done in cycle 1). Result is `{operand_1, 32'hFFFFFFFF}` with no sign fix-up.
- Undefined: full 32-cycle iteration as above. Results are architecturally UNPREDICTABLE either way.

Decomposition:
- Shared include (funct.v): existing `FUNCT_*`/`FUNCT2_*` codes, reused and not redefined.
- Shared include (new): FSM state encodings (DIV_IDLE=2'b00, DIV_ON=2'b01, DIV_END=2'b10) and `DIV_CYCLES`.
- Sub-module `div_core`: iterative unsigned divider with start/abort/done. mult_div_unit wraps it with sign handling, multiply logic and the output mux.

Test Plan:
- MULT 0xFFFFFFFF×0x00000002 → done=1 same cycle, result 0xFFFFFFFF_FFFFFFFE.
- MULTU with the same operands → result 0x00000001_FFFFFFFE.
- MADD hi=0, lo=5, 3×4 → 0x00000000_00000011.
- MSUBU hi=0, lo=0, 1×1 → 0xFFFFFFFF_FFFFFFFF.
- DIVU 100/7 → done=0 for cycles 0–32, done=1 in cycle 33, result `{0x2, 0xE}`.
- DIV -7/2 (0xFFFFFFF9, 0x2) → result `{0xFFFFFFFF, 0xFFFFFFFD}`; with stall_hold=1 during cycles 33–35, done stays 1 and the result is stable.
- DIV started, flush at cycle 10 → IDLE next cycle, done=0; a fresh DIVU 9/3 then completes in 33 cycles with result `{0, 3}`.
- DIVU 5/0 → with MULT_DIV_DIV_ZERO_FAST_EN: done in cycle 1, `{5, 0xFFFFFFFF}`; without: done in cycle 33, `{5, 0xFFFFFFFF}`.
- rst_n asserted mid-division → done=0 and result=0 immediately (async); DIV_IDLE after release.
